game_tick_sched: RTL and testbench

GAME_TICK_SCHED -- requirements
Module: game_tick_sched

---
 rtl/game_timer_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/game_tick_sched.sv | 93 +++++++++
 tb/tb_game_tick_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared constants for the game tick scheduler.
//   NCH            : number of timer channels
//   chan_e         : channel index names (alien march, player shot, alien shot, UFO)
//   DEF_*          : default channel-0 floor and reset periods
package game_timer_pkg;

    localparam int unsigned NCH = 4;

    typedef enum logic [1:0] {
        CH_MARCH = 2'd0,
        CH_PSHOT = 2'd1,
        CH_ASHOT = 2'd2,
        CH_UFO   = 2'd3
    } chan_e;

    localparam int unsigned DEF_MINP  = 4;
    localparam int unsigned DEF_INIT0 = 32;
    localparam int unsigned DEF_INIT1 = 2;
    localparam int unsigned DEF_INIT2 = 8;
    localparam int unsigned DEF_INIT3 = 255;

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: counts 0..DIV-1 and wraps, frozen while paused.
//   CLK   : system clock
//   Rst   : synchronous active-low reset
//   Pause : hold the count
//   Tick  : strobe, high during the final count cycle when not paused.
//           The parent registers it, so the visible tick lands one cycle later.
module tick_prescaler #(
    parameter int unsigned DIV = 50000
) (
    input  logic CLK,
    input  logic Rst,
    input  logic Pause,
    output logic Tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (!Pause) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign Tick = Rst && !Pause && (cnt == LAST);

endmodule

// File: rtl/game_tick_sched.sv
// Game tick scheduler: a base-tick prescaler plus four period channels,
// each firing once every P base ticks.
//   CLK     : system clock
//   Rst     : synchronous active-low reset
//   Pause   : freeze prescaler and channels; Tick/Fire stay low
//   Wr      : period write strobe (restarts the selected channel)
//   WrSel   : channel written by Wr
//   WrData  : new period, 0 disables the channel
//   SpeedUp : shorten channel-0 period by one, floored at MINP
//   Tick    : registered one-cycle base-tick pulse
//   Fire    : registered one-cycle pulse per channel
module game_tick_sched
    import game_timer_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned PW    = 8,
    parameter int unsigned MINP  = DEF_MINP,
    parameter int unsigned INIT0 = DEF_INIT0,
    parameter int unsigned INIT1 = DEF_INIT1,
    parameter int unsigned INIT2 = DEF_INIT2,
    parameter int unsigned INIT3 = DEF_INIT3
) (
    input  logic           CLK,
    input  logic           Rst,
    input  logic           Pause,
    input  logic           Wr,
    input  logic [1:0]     WrSel,
    input  logic [PW-1:0]  WrData,
    input  logic           SpeedUp,
    output logic           Tick,
    output logic [NCH-1:0] Fire
);

    localparam logic [PW-1:0] INIT_P [NCH] = '{PW'(INIT0), PW'(INIT1), PW'(INIT2), PW'(INIT3)};

    logic tick_now;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK   (CLK),
        .Rst   (Rst),
        .Pause (Pause),
        .Tick  (tick_now)
    );

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            Tick <= 1'b0;
        end else begin
            Tick <= tick_now;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam bit IS_MARCH = (g == int'(CH_MARCH));

        logic [PW-1:0] per;
        logic [PW-1:0] cnt;
        logic          fire_q;

        // A write restarts the channel and pre-empts both the tick and SpeedUp.
        // Reload uses the period held before any SpeedUp in the same cycle.
        always_ff @(posedge CLK) begin
            if (!Rst) begin
                per    <= INIT_P[g];
                cnt    <= INIT_P[g];
                fire_q <= 1'b0;
            end else begin
                fire_q <= 1'b0;
                if (Wr && (WrSel == 2'(g))) begin
                    per <= WrData;
                    cnt <= WrData;
                end else begin
                    if (per == '0) begin
                        cnt <= '0;
                    end else if (tick_now) begin
                        if (cnt <= PW'(1)) begin
                            cnt    <= per;
                            fire_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    if (IS_MARCH && SpeedUp && (per > PW'(MINP))) begin
                        per <= per - 1'b1;
                    end
                end
            end
        end

        assign Fire[g] = fire_q;
    end

endmodule

// File: tb/tb_game_tick_sched.sv
module tb_game_tick_sched;

    localparam int DIV = 4;
    localparam int INIT_V [4] = '{32, 2, 8, 255};

    logic       CLK = 1'b0;
    logic       Rst = 1'b0;
    logic       Pause = 1'b0;
    logic       Wr = 1'b0;
    logic [1:0] WrSel = 2'd0;
    logic [7:0] WrData = 8'd0;
    logic       SpeedUp = 1'b0;
    logic       Tick;
    logic [3:0] Fire;

    game_tick_sched #(
        .DIV   (DIV),
        .PW    (8),
        .MINP  (4),
        .INIT0 (32),
        .INIT1 (2),
        .INIT2 (8),
        .INIT3 (255)
    ) dut (
        .CLK     (CLK),
        .Rst     (Rst),
        .Pause   (Pause),
        .Wr      (Wr),
        .WrSel   (WrSel),
        .WrData  (WrData),
        .SpeedUp (SpeedUp),
        .Tick    (Tick),
        .Fire    (Fire)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int       cyc;
        logic     tick;
        logic [3:0] fire;
    } exp_t;

    exp_t sbq[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int f0_last = -1;
    int f0_prev = -1;
    int f1_count = 0;

    // Behavioural model: tick index counter and absolute tick of each channel's next fire.
    int phase = 0;
    int ticks = 0;
    int per [4] = '{32, 2, 8, 255};
    int nxt [4] = '{32, 2, 8, 255};

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every cycle compare {Tick,Fire} against the scoreboard head (or idle).
    initial begin
        forever begin
            exp_t e;
            @(posedge CLK);
            cyc++;
            #1;
            e.cyc  = cyc;
            e.tick = 1'b0;
            e.fire = 4'd0;
            if (sbq.size() > 0 && sbq[0].cyc == cyc) e = sbq.pop_front();
            check($sformatf("out@%0d {Tick,Fire}", cyc), int'({Tick, Fire}), int'({e.tick, e.fire}));
            if (Fire[0]) begin
                f0_prev = f0_last;
                f0_last = cyc;
            end
            if (Fire[1]) f1_count++;
        end
    end

    task automatic step(input logic r, input logic p, input logic w, input logic [1:0] s,
                        input logic [7:0] d, input logic su);
        bit         tk;
        logic [3:0] f;
        exp_t       e;
        @(negedge CLK);
        Rst = r; Pause = p; Wr = w; WrSel = s; WrData = d; SpeedUp = su;
        f = 4'd0;
        if (!r) begin
            phase = 0;
            ticks = 0;
            for (int i = 0; i < 4; i++) begin
                per[i] = INIT_V[i];
                nxt[i] = INIT_V[i];
            end
        end else begin
            tk = !p && (phase == DIV - 1);
            if (!p) phase = (phase == DIV - 1) ? 0 : phase + 1;
            if (tk) ticks++;
            for (int i = 0; i < 4; i++) begin
                if (w && s == i) begin
                    per[i] = d;
                    nxt[i] = ticks + d;
                end else if (tk && per[i] != 0 && ticks == nxt[i]) begin
                    f[i]   = 1'b1;
                    nxt[i] = ticks + per[i];
                end
            end
            if (su && !(w && s == 0) && per[0] > 4) per[0]--;
            if (tk || f != 4'd0) begin
                e.cyc  = cyc + 1;
                e.tick = tk;
                e.fire = f;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    initial begin
        int c0;
        int guard;

        // Reset, then free run long enough for the UFO channel (255 ticks).
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        idle(1100);

        // Disable player shot for 100+ ticks, then restart with period 3.
        step(1'b1, 1'b0, 1'b1, 2'd1, 8'd0, 1'b0);
        c0 = f1_count;
        idle(420);
        check("fire1_disabled_count", f1_count - c0, 0);
        step(1'b1, 1'b0, 1'b1, 2'd1, 8'd3, 1'b0);
        idle(60);

        // 30 SpeedUp pulses: channel-0 period floors at 4 ticks = 16 cycles.
        repeat (30) begin
            step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
            idle(1);
        end
        idle(250);
        check("fire0_spacing_floor", f0_last - f0_prev, 4 * DIV);

        // Pause 10 cycles mid-count.
        guard = 0;
        while (phase != 1 && guard < 2 * DIV) begin idle(1); guard++; end
        repeat (10) step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
        idle(100);

        // Write to channel 2 in the very tick cycle it would fire.
        guard = 0;
        while (!(phase == DIV - 1 && per[2] != 0 && nxt[2] == ticks + 1) && guard < 80) begin
            idle(1);
            guard++;
        end
        check("ch2_align_found", int'(guard < 80), 1);
        step(1'b1, 1'b0, 1'b1, 2'd2, 8'd5, 1'b0);
        idle(120);

        // SpeedUp and Wr to channel 0 together: write wins, period 10 ticks.
        step(1'b1, 1'b0, 1'b1, 2'd0, 8'd10, 1'b1);
        idle(200);
        check("fire0_spacing_wr_wins", f0_last - f0_prev, 10 * DIV);

        // One-cycle reset mid-count.
        guard = 0;
        while (phase != 2 && guard < 2 * DIV) begin idle(1); guard++; end
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        idle(300);

        idle(3);
        check("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
